// File: rtl/riscv_mini_pkg.sv
// riscv_mini_pkg: shared widths, NOP word, opcode constants and loader FSM states for the mini RISC-V fetch path
package riscv_mini_pkg;
  localparam int INSTR_W = 16;
  localparam int BYTE_W = 8;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h2003;
  localparam logic [1:0] OP_R = 2'b00;
  localparam logic [1:0] OP_I = 2'b01;
  localparam logic [1:0] OP_L = 2'b10;
  localparam logic [1:0] OP_S = 2'b11;
  typedef enum logic {LO, HI} asm_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two FIFO (clk, rst, flush, push/din in; head, fill, full, empty out), flush outranks push/pop
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [FW-1:0]    fill,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = fill == FW'(DEPTH);
  assign empty = fill == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + FW'(do_push) - FW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: assembles little-endian byte pairs (byte_in/valid/ready) into 16-bit words for the core (instr_out/valid/ready), NOP when empty, with fill, lo_pending and issue_count status
module instr_loader
  import riscv_mini_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter logic [15:0] NOP_INSTR = riscv_mini_pkg::NOP_INSTR,
  parameter int CNT_W = 8,
  localparam int FW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [15:0]      instr_out,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [FW-1:0]    fill,
  output logic             lo_pending,
  output logic [CNT_W-1:0] issue_count
);
  asm_state_t state, state_n;
  logic [BYTE_W-1:0] lo_reg;
  logic [INSTR_W-1:0] head;
  logic full, empty, fire, pop;
  assign byte_ready = !(state == HI && full);
  assign fire = byte_valid && byte_ready;
  assign pop = instr_valid && instr_ready;
  assign lo_pending = state == HI;
  assign instr_valid = !empty;
  assign instr_out = instr_valid ? head : NOP_INSTR;
  always_comb begin
    state_n = flush ? LO : !fire ? state : state == LO ? HI : LO;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LO;
      issue_count <= '0;
    end else begin
      state <= state_n;
      if (pop) issue_count <= issue_count + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (fire && state == LO) lo_reg <= byte_in;
  end
  sync_fifo #(.WIDTH(INSTR_W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(fire && state == HI),
    .din({byte_in, lo_reg}),
    .pop(pop),
    .head(head),
    .fill(fill),
    .full(full),
    .empty(empty)
  );
endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Upstream fetch stage for the 8-bit mini RISC-V core.
- Accepts a byte stream over an 8-bit valid/ready interface and assembles little-endian 16-bit instructions: low byte first, which maps to instruction[7:0].
- Buffers assembled instructions in a small FIFO and presents one per cycle to the core's 16-bit instruction input.
- When no instruction is buffered, presents a harmless NOP so the core never writes a register.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- NOP_INSTR, 16'h2003, word driven when FIFO empty; opcode 11, funct3 001, so no write and result 0.
- CNT_W, 8, width of issued-instruction counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  drop buffered instructions and any pending low byte.
- byte_in  in  8  instruction byte.
- byte_valid  in  1  byte_in valid.
- byte_ready  out  1  loader accepts byte this cycle.
- instr_out  out  16  instruction to core; NOP_INSTR when empty.
- instr_valid  out  1  instr_out comes from the FIFO.
- instr_ready  in  1  core consumes instr_out this cycle.
- fill  out  $clog2(DEPTH+1)  number of buffered instructions.
- lo_pending  out  1  low byte held, waiting for high byte.
- issue_count  out  CNT_W  instructions consumed, wrapping.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: fill=0, lo_pending=0, issue_count=0, instr_valid=0, instr_out=NOP_INSTR, byte_ready=1. FIFO contents are don't-care.
- Assembly FSM has two states:
  - LO: byte accepted → latch byte into lo_reg, go to HI.
  - HI: byte accepted → push {byte_in, lo_reg} into FIFO, go to LO.
- byte_ready = !(state==HI && fill==DEPTH).
  - A low byte is always accepted.
  - A high byte stalls while the FIFO is full.
  - A pop in the same cycle does not raise byte_ready; there is no combinational ready-from-pop path.
- Byte transfer occurs when byte_valid && byte_ready. lo_pending = (state==HI).
- Pop occurs when instr_valid && instr_ready.
  - instr_valid = (fill != 0).
  - instr_out = FIFO head when valid, else NOP_INSTR.
  - instr_ready while empty has no effect.
- Latency: high byte accepted in cycle N → instr_valid=1 in cycle N+1 if the FIFO was empty. There is no bypass.
- Simultaneous push and pop: fill is unchanged and ordering is preserved. Pointers wrap modulo DEPTH.
- issue_count increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
- flush:
  - Next cycle: fill=0, FSM=LO, pointers=0.
  - A byte accepted in the flush cycle is discarded.
  - A pop in the flush cycle still counts in issue_count.
  - flush has priority over push.
- rst has priority over flush and everything else.
- Reset asserted mid-instruction, i.e. in HI state, discards the low byte.
- No error or overflow state exists. Back-pressure is the only full-handling mechanism.

Decomposition:
- Shared package riscv_mini_pkg holds:
  - INSTR_W=16 and BYTE_W=8.
  - NOP_INSTR constant.
  - Opcode constants: R=00, I=01, L=10, S=11.
- One sub-module: sync_fifo (parameters WIDTH and DEPTH; push/pop/flush; head, fill, full, empty).
- instr_loader holds the assembly FSM, output mux and issue counter.

Test Plan:
- Reset/empty: assert rst 2 cycles, then idle → instr_out=16'h2003, instr_valid=0, fill=0, byte_ready=1, issue_count=0.
- Assembly: bytes 8'h25, 8'h41 with instr_ready=0 → after 2nd byte: lo_pending=0, fill=1, instr_valid=1, instr_out=16'h4125. Assert instr_ready → next cycle fill=0, issue_count=1, instr_out=16'h2003.
- Full/back-pressure with DEPTH=4:
  - Push 4 instructions (16'h0001..16'h0004), then low byte 8'hAA → accepted, lo_pending=1, byte_ready=0 while high byte 8'hBB is offered.
  - Pop once → byte_ready=1 next cycle, 16'hBBAA lands in entry 5.
  - Drained order: 0001, 0002, 0003, 0004, BBAA.
- Simultaneous push/pop: fill=2, high byte accepted while instr_ready=1 → fill stays 2, FIFO order preserved across pointer wrap (≥8 instructions streamed).
- Flush: fill=3, lo_pending=1, assert flush with byte_valid=1 → next cycle fill=0, lo_pending=0, instr_out=16'h2003. The discarded byte does not appear in any later instruction.
- Counter wrap/reset mid-op: consume 256 instructions → issue_count returns to 0. Then send low byte, assert rst, send 8'h12, 8'h34 → instruction 16'h3412, proving the pending byte was discarded.
